// File: rtl/mode_ctrl.sv
// mode_ctrl
// Synchronises and debounces the raw mode switches, holds the accepted (stable)
// mode code and decodes it into a one-hot vector plus a legality flag.
// It also emits single-cycle pulses for any accepted mode change, and for
// leaving an adjust code (MSB set):
// - to its matching run code (commit);
// - or to any other code (abort).
//
// Optional feature, enabled by defining MODE_CTRL_LOCK_EN:
// - adds a `lock` input that freezes accepts while high;
// - debouncing restarts once `lock` is released.
module mode_ctrl #(
    parameter int                    SW_W       = 3,
    parameter int                    DEB_CYCLES = 4,
    parameter logic [(2**SW_W)-1:0]  VALID_MASK = 8'b0101_0111,
    parameter int                    RESET_CODE = 0
) (
    input  logic                   clk,
    input  logic                   reset,
`ifdef MODE_CTRL_LOCK_EN
    input  logic                   lock,
`endif
    input  logic [SW_W-1:0]        sw,
    output logic [SW_W-1:0]        mode_code,
    output logic [(2**SW_W)-1:0]   mode_onehot,
    output logic                   mode_valid,
    output logic                   mode_change,
    output logic                   commit_pulse,
    output logic                   abort_pulse,
    output logic [SW_W-2:0]        commit_code
);

    localparam int OH_W  = 2**SW_W;
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [SW_W-1:0]  RST_CODE = SW_W'(RESET_CODE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    // Synchroniser stages, debounce candidate/counter and accepted code.
    logic [SW_W-1:0]  sw_p0;
    logic [SW_W-1:0]  sw_p1;
    logic [SW_W-1:0]  cand_p2;
    logic [CNT_W-1:0] cnt_p2;
    logic [SW_W-1:0]  stable;

    // When high, the debounce counter is held at zero and no accept may occur.
    logic hold;

`ifdef MODE_CTRL_LOCK_EN
    // Delayed copy of lock.
    // The first clock after release still counts as held.
    // This makes debouncing restart from scratch once the lock is released.
    logic lock_d;

    // Track the previous lock level so the release edge extends the hold by one clock
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_d <= 1'b0;
        end else begin
            lock_d <= lock;
        end
    end

    assign hold = lock | lock_d;
`else
    assign hold = 1'b0;
`endif

    // Two-flop synchroniser on the raw switches; nothing sits between the flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_p0 <= RST_CODE;
            sw_p1 <= RST_CODE;
        end else begin
            sw_p0 <= sw;
            sw_p1 <= sw_p0;
        end
    end

    // Debounce, accept the settled candidate and register the event pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cand_p2      <= RST_CODE;
            cnt_p2       <= '0;
            stable       <= RST_CODE;
            mode_change  <= 1'b0;
            commit_pulse <= 1'b0;
            abort_pulse  <= 1'b0;
            commit_code  <= '0;
        end else begin
            mode_change  <= 1'b0;
            commit_pulse <= 1'b0;
            abort_pulse  <= 1'b0;
            if (sw_p1 != cand_p2) begin
                // Input moved: restart the debounce window on the new value.
                cand_p2 <= sw_p1;
                cnt_p2  <= '0;
            end else if (hold) begin
                cnt_p2 <= '0;
            end else if (cnt_p2 < CNT_LAST) begin
                cnt_p2 <= cnt_p2 + CNT_W'(1);
            end else if (cand_p2 != stable) begin
                // Candidate held long enough and differs: accept it.
                stable      <= cand_p2;
                mode_change <= 1'b1;
                if (stable[SW_W-1]) begin
                    // Leaving an adjust code.
                    // Going to its own run code commits; any other target aborts.
                    commit_code <= stable[SW_W-2:0];
                    if (cand_p2 == {1'b0, stable[SW_W-2:0]}) begin
                        commit_pulse <= 1'b1;
                    end else begin
                        abort_pulse <= 1'b1;
                    end
                end
            end
        end
    end

    // Decode the stable code; illegal codes give an all-zero one-hot vector
    always_comb begin
        mode_code   = stable;
        mode_valid  = VALID_MASK[stable];
        mode_onehot = '0;
        if (VALID_MASK[stable]) begin
            mode_onehot = OH_W'(1) << stable;
        end
    end

endmodule
